// File: rtl/next_pc_predictor_pkg.sv
// next_pc_predictor_pkg
//   Shared types and constants for the next-PC predictor: address type, BTB entry layout,
//   2-bit direction counter encodings, default exception vector and the saturating
//   counter helper.
package next_pc_predictor_pkg;

    typedef logic [31:0] addr_t;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

    // 2-bit direction counter states
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Widest tag needed (smallest table, 4 entries: 32 - 2 - 2). Larger tables leave the
    // upper tag bits at zero.
    localparam int unsigned TAG_MAX_W = 28;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [29:0]          target;  // word address of the taken target
        logic [1:0]           ctr;
    } bp_entry_t;

    // Saturating up/down step of a 2-bit direction counter.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// bp_btb
//   Direct-mapped branch target buffer: storage, lookup and update.
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     lookup_pc              PC of the current fetch group
//     pred_taken             lookup hit with counter weakly/strongly taken
//     pred_target            stored target of the looked-up entry
//     upd_valid/pc/target/taken  resolved-branch update
//   The lookup reads registered state only, so a same-cycle update to the same index is
//   not visible until the following cycle.
module bp_btb
    import next_pc_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int unsigned IDX_W     = $clog2(ENTRIES);
    localparam int unsigned TAG_SHIFT = 2 + IDX_W;

    bp_entry_t table_q [ENTRIES];
    bp_entry_t table_d [ENTRIES];

    logic [IDX_W-1:0]     look_idx;
    logic [IDX_W-1:0]     upd_idx;
    logic [TAG_MAX_W-1:0] look_tag;
    logic [TAG_MAX_W-1:0] upd_tag;
    bp_entry_t            look_e;
    bp_entry_t            upd_e;
    logic                 upd_hit;

    // Byte-offset bits never take part in indexing, tagging or target storage.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign look_idx = lookup_pc[2 +: IDX_W];
    assign upd_idx  = upd_pc[2 +: IDX_W];
    assign look_tag = TAG_MAX_W'(lookup_pc >> TAG_SHIFT);
    assign upd_tag  = TAG_MAX_W'(upd_pc >> TAG_SHIFT);

    assign look_e = table_q[look_idx];
    assign upd_e  = table_q[upd_idx];

    assign pred_taken  = look_e.valid && (look_e.tag == look_tag) && look_e.ctr[1];
    assign pred_target = {look_e.target, 2'b00};

    assign upd_hit = upd_e.valid && (upd_e.tag == upd_tag);

    always_comb begin
        table_d = table_q;
        if (upd_valid) begin
            if (upd_hit) begin
                table_d[upd_idx].ctr = ctr_step(upd_e.ctr, upd_taken);
                if (upd_taken) table_d[upd_idx].target = upd_target[31:2];
            end else if (upd_taken) begin
                // Allocate weakly taken; a not-taken miss leaves the entry alone.
                table_d[upd_idx].valid  = 1'b1;
                table_d[upd_idx].tag    = upd_tag;
                table_d[upd_idx].target = upd_target[31:2];
                table_d[upd_idx].ctr    = WT;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].ctr    <= WNT;
            end
        end else begin
            table_q <= table_d;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// next_pc_predictor
//   Selects the next fetch PC. Priority: exception (EXC_VECTOR), eret (epc), mispredict
//   (redirect_pc), BTB taken prediction (stored target), sequential (cur_pc + FETCH_BYTES).
//   Also keeps a saturating count of mispredict cycles.
//   Configuration macro BP_BTB_EN: when defined the bp_btb table is built; when undefined
//   there is no table, pred_taken is 0 and the upd_* inputs are ignored.
//   Ports:
//     clk, resetn                   clock, asynchronous active-low reset
//     cur_pc                        PC of the current fetch group
//     cp0_flush, eret, epc          exception / exception-return redirects
//     mispredict, redirect_pc       branch-resolution redirect
//     upd_valid/pc/target/taken     resolved-branch BTB update
//     next_pc, pred_taken           next fetch PC and BTB-prediction flag
//     mispredict_cnt                saturating mispredict-cycle counter
module next_pc_predictor #(
    parameter int unsigned ENTRIES     = 64,
    parameter int unsigned FETCH_BYTES = 8,
    parameter logic [31:0] EXC_VECTOR  = next_pc_predictor_pkg::EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] cur_pc,
    input  logic        cp0_flush,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        mispredict,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic [31:0] next_pc,
    output logic        pred_taken,
    output logic [31:0] mispredict_cnt
);

    import next_pc_predictor_pkg::*;

    logic  btb_taken;
    addr_t btb_target;
    addr_t seq_pc;
    logic  [31:0] mispredict_cnt_q;
    logic  [31:0] mispredict_cnt_d;

`ifdef BP_BTB_EN
    bp_btb #(
        .ENTRIES(ENTRIES)
    ) u_btb (
        .clk        (clk),
        .resetn     (resetn),
        .lookup_pc  (cur_pc),
        .pred_taken (btb_taken),
        .pred_target(btb_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );
`else
    assign btb_taken  = 1'b0;
    assign btb_target = '0;

    logic        unused_upd;
    logic [31:0] unused_cfg;
    assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign unused_cfg = 32'(ENTRIES);
`endif

    assign seq_pc = cur_pc + 32'(FETCH_BYTES);

    always_comb begin
        next_pc    = seq_pc;
        pred_taken = 1'b0;
        if (cp0_flush) begin
            next_pc = EXC_VECTOR;
        end else if (eret) begin
            next_pc = epc;
        end else if (mispredict) begin
            next_pc = redirect_pc;
        end else if (btb_taken) begin
            next_pc    = btb_target;
            pred_taken = 1'b1;
        end
    end

    always_comb begin
        mispredict_cnt_d = mispredict_cnt_q;
        if (mispredict && (mispredict_cnt_q != 32'hffffffff)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mispredict_cnt_q <= '0;
        end else begin
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: doc/next_pc_predictor.md
NEXT_PC_PREDICTOR -- requirements
Module: next_pc_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, BTB entry count (power of two, 4..1024).
REQ-002 SHALL have parameter FETCH_BYTES, default 8, sequential PC increment per fetch group.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'hbfc00380, exception entry address.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cur_pc  in  32  PC of the current fetch group.
REQ-007 SHALL have port cp0_flush  in  1  exception redirect.
REQ-008 SHALL have port eret  in  1  exception-return redirect.
REQ-009 SHALL have port epc  in  32  eret target.
REQ-010 SHALL have port mispredict  in  1  execute-stage branch resolution disagrees with the prediction.
REQ-011 SHALL have port redirect_pc  in  32  correct PC on mispredict.
REQ-012 SHALL have port upd_valid  in  1  a branch resolved this cycle.
REQ-013 SHALL have ports upd_pc/upd_target  in  32 each  resolved branch PC and its target; upd_taken  in  1  resolved direction.
REQ-014 SHALL have port next_pc  out  32  PC for the next fetch.
REQ-015 SHALL have port pred_taken  out  1  next_pc came from a BTB taken prediction.
REQ-016 SHALL have port mispredict_cnt  out  32  saturating count of mispredict cycles.

Function
REQ-017 next_pc SHALL be combinational from inputs and current state, with priority cp0_flush -> EXC_VECTOR, eret -> epc, mispredict -> redirect_pc, BTB predict-taken -> stored target, else cur_pc + FETCH_BYTES (mod 2^32).
REQ-018 BTB SHALL be direct-mapped: index = pc[2 +: log2(ENTRIES)]; tag = remaining upper bits; entry = valid, tag, 30-bit target word, 2-bit counter.
REQ-019 Predict-taken SHALL require valid, tag match and counter >= 2; pred_taken SHALL be 0 whenever a higher-priority source wins.
REQ-020 On upd_valid with hit: counter SHALL increment (taken) or decrement (not taken), saturating at 3 and 0; on a taken hit the target SHALL be rewritten.
REQ-021 On upd_valid with miss and upd_taken=1: the entry SHALL be allocated with counter 2 (weakly taken); with miss and upd_taken=0: no change.
REQ-022 An update and a lookup to the same index in one cycle: the lookup SHALL see pre-update contents (no bypass).
REQ-023 Updates SHALL be applied regardless of cp0_flush/eret/mispredict in the same cycle.
REQ-024 mispredict_cnt SHALL increment by 1 on each cycle with mispredict=1, holding at 32'hffffffff.

Reset
REQ-025 While resetn=0: all valid bits cleared, counters 1, mispredict_cnt 0, pred_taken 0, next_pc follows REQ-017 with no BTB hits.
REQ-026 Reset asserted mid-update SHALL discard that update.

Configuration
REQ-027 Macro BP_BTB_EN: defined -> BTB and REQ-018..REQ-022 present; undefined -> no table storage, pred_taken tied 0, upd_* ignored, next_pc uses REQ-017 without the BTB term; mispredict_cnt kept in both.

Structure
REQ-028 bp_entry_t, counter constants (SNT=0, WNT=1, WT=2, ST=3) and EXC_VECTOR default SHALL live in a shared package; addr_t from the common header.
REQ-029 Table storage, lookup and update SHALL be a sub-module bp_btb; next_pc_predictor holds priority mux and counter.

Verification
REQ-030 After reset, cur_pc=32'hbfc00000, no control -> next_pc=32'hbfc00008, pred_taken=0.
REQ-031 Update pc=32'h80001000 taken target 32'h80002000, then cur_pc=32'h80001000 -> next_pc=32'h80002000, pred_taken=1.
REQ-032 From REQ-031, two not-taken updates -> counter 0; lookup -> next_pc=32'h80001008, pred_taken=0.
REQ-033 cp0_flush, eret (epc=32'h80000100) and mispredict all asserted -> next_pc=32'hbfc00380; drop cp0_flush -> 32'h80000100.
REQ-034 Aliasing pc 32'h80001000 vs 32'h90001000 with ENTRIES=64 -> tag mismatch, sequential prediction.
REQ-035 Hold mispredict 3 cycles, then resetn low mid-sequence -> mispredict_cnt 3 then 0 asynchronously.
